// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks the OV7670 config ROM from address 0 and issues one SCCB write per {reg,val} entry,
// honouring FFF0 delay markers and the FFFF end marker.
module ov7670_config_sequencer #(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    output logic        o_rom_clk_en,
    input  logic [15:0] i_rom_dout,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [7:0]  o_cmd_reg,
    output logic [7:0]  o_cmd_val,
    input  logic        i_sccb_done,
    input  logic        i_sccb_err,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);
    localparam int CW = DELAY_CYCLES > 1 ? $clog2(DELAY_CYCLES) : 1;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, WAIT_WR, DELAY, FIN} state_t;
    state_t        r_state, w_state;
    logic [7:0]    r_addr, w_addr, r_reg, w_reg, r_val, w_val;
    logic          r_busy, w_busy, r_done, w_done, r_error, w_error, w_next;
    logic [RW-1:0] r_retry, w_retry;
    logic [CW-1:0] r_cnt, w_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_reg   <= '0;
            r_val   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_retry <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_reg   <= w_reg;
            r_val   <= w_val;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_error <= w_error;
            r_retry <= w_retry;
            r_cnt   <= w_cnt;
        end
    end
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_reg   = r_reg;
        w_val   = r_val;
        w_busy  = r_busy;
        w_done  = r_done;
        w_error = r_error;
        w_retry = r_retry;
        w_cnt   = r_cnt;
        w_next  = 1'b0;
        case (r_state)
            IDLE: if (i_start) begin
                w_state = FETCH;
                w_addr  = '0;
                w_done  = 1'b0;
                w_error = 1'b0;
                w_busy  = 1'b1;
            end
            FETCH: w_state = DECODE;
            DECODE: if (i_rom_dout == 16'hFFFF) w_state = FIN;
                else if (i_rom_dout == 16'hFFF0) begin
                    w_state = DELAY;
                    w_cnt   = CW'(DELAY_CYCLES - 1);
                end else begin
                    w_reg   = i_rom_dout[15:8];
                    w_val   = i_rom_dout[7:0];
                    w_retry = '0;
                    w_state = SEND;
                end
            SEND: if (i_cmd_ready) w_state = WAIT_WR;
            // an error pulse takes priority over a coincident done pulse
            WAIT_WR: if (i_sccb_err) begin
                    if (r_retry >= RW'(MAX_RETRY)) begin
                        w_error = 1'b1;
                        w_state = FIN;
                    end else begin
                        w_retry = r_retry + 1'b1;
                        w_state = SEND;
                    end
                end else if (i_sccb_done) w_next = 1'b1;
            DELAY: if (r_cnt == '0) w_next = 1'b1; else w_cnt = r_cnt - 1'b1;
            FIN: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
        if (w_next) begin
            if (r_addr == 8'hFF) begin
                w_error = 1'b1;
                w_state = FIN;
            end else begin
                w_addr  = r_addr + 1'b1;
                w_state = FETCH;
            end
        end
    end
    assign o_rom_addr   = r_addr;
    assign o_rom_clk_en = r_state == FETCH;
    assign o_cmd_valid  = r_state == SEND;
    assign o_cmd_reg    = r_reg;
    assign o_cmd_val    = r_val;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
endmodule
